// File: rtl/bias_layer_sequencer_pkg.sv
// Shared constants for the bias layer sequencer: FSM state encoding and parameter defaults.
package bias_layer_sequencer_pkg;

    localparam int unsigned BRAM_DATA_WIDTH_DEF = 32;
    localparam int unsigned CH_WIDTH_DEF        = 12;
    localparam int unsigned LOAD_TIMEOUT_DEF    = 4096;
    localparam int unsigned STATE_W             = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KICK = 3'd1,
        ST_LOAD      = 3'd2,
        ST_READ_KICK = 3'd3,
        ST_WAIT_BIAS = 3'd4,
        ST_PRESENT   = 3'd5,
        ST_FINISH    = 3'd6
    } state_e;

endpackage

// File: rtl/bias_layer_sequencer_chan_counter.sv
// Channel counter for one layer: latches the channel total at start and
// flags the last channel one register stage ahead of its use.
module bias_chan_counter
    import bias_layer_sequencer_pkg::*;
#(
    parameter int unsigned CH_WIDTH = CH_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [CH_WIDTH-1:0] size_i,
    input  logic                incr_i,
    output logic                last_o
);

    logic [CH_WIDTH-1:0] cnt_q, cnt_d;
    logic [CH_WIDTH-1:0] total_q, total_d;
    logic                last_q, last_d;

    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        if (load_i) begin
            cnt_d   = '0;
            total_d = size_i;
        end else if (clear_i) begin
            cnt_d   = '0;
            total_d = '0;
        end else if (incr_i) begin
            cnt_d = cnt_q + CH_WIDTH'(1);
        end
        // A zero total never matches, so the wrapped total-1 is harmless
        last_d = (total_d != '0) && (cnt_d == total_d - CH_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            total_q <= '0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            total_q <= total_d;
            last_q  <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/bias_layer_sequencer.sv
// Per-layer sequencer for the bias BRAM: optional load phase, then one bias
// word per output channel handed to the PE array over a valid/ready handshake.
module bias_layer_sequencer
    import bias_layer_sequencer_pkg::*;
#(
    parameter int unsigned BRAM_DATA_WIDTH = BRAM_DATA_WIDTH_DEF,
    parameter int unsigned CH_WIDTH        = CH_WIDTH_DEF,
    parameter int unsigned LOAD_TIMEOUT    = LOAD_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       reload_bias,
    input  logic                       abort,
    input  logic [CH_WIDTH-1:0]        output_channel_size,
    input  logic                       write_bias_finish,
    input  logic                       bias_from_bram_valid,
    input  logic [BRAM_DATA_WIDTH-1:0] bias_from_bram,
    input  logic                       bias_ready,
    output logic                       write_en,
    output logic                       transfer_start,
    output logic                       bram_control_add,
    output logic                       layer_finish,
    output logic [BRAM_DATA_WIDTH-1:0] bias_data,
    output logic                       bias_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       err_timeout,
    output logic [STATE_W-1:0]         state_o
);

    localparam int unsigned TO_W = $clog2(LOAD_TIMEOUT + 1);

    state_e                     state_q, state_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic                       write_en_q, write_en_d;
    logic                       transfer_start_q, transfer_start_d;
    logic                       bram_add_q, bram_add_d;
    logic                       layer_finish_q, layer_finish_d;
    logic [BRAM_DATA_WIDTH-1:0] bias_data_q, bias_data_d;
    logic                       bias_valid_q, bias_valid_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic start_acc;
    logic size_zero;
    logic abort_act;
    logic timeout_hit;
    logic handshake;
    logic ch_last;
    logic ch_load, ch_clear;

    assign start_acc   = (state_q == ST_IDLE) && start;
    assign size_zero   = (output_channel_size == '0);
    // FINISH already heads back to IDLE, so abort there changes nothing
    assign abort_act   = abort && (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign timeout_hit = (to_cnt_q == TO_W'(LOAD_TIMEOUT - 1));
    assign handshake   = (state_q == ST_PRESENT) && bias_ready;

    bias_chan_counter #(
        .CH_WIDTH (CH_WIDTH)
    ) u_chan_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (ch_clear),
        .load_i  (ch_load),
        .size_i  (output_channel_size),
        .incr_i  (bram_add_d),
        .last_o  (ch_last)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            to_cnt_q         <= '0;
            write_en_q       <= 1'b0;
            transfer_start_q <= 1'b0;
            bram_add_q       <= 1'b0;
            layer_finish_q   <= 1'b0;
            bias_data_q      <= '0;
            bias_valid_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            to_cnt_q         <= to_cnt_d;
            write_en_q       <= write_en_d;
            transfer_start_q <= transfer_start_d;
            bram_add_q       <= bram_add_d;
            layer_finish_q   <= layer_finish_d;
            bias_data_q      <= bias_data_d;
            bias_valid_q     <= bias_valid_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_q            <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = ST_FINISH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !size_zero) begin
                        state_d = reload_bias ? ST_LOAD_KICK : ST_READ_KICK;
                    end
                end
                ST_LOAD_KICK: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (write_bias_finish) begin
                        state_d = ST_READ_KICK;
                    end else if (timeout_hit) begin
                        state_d = ST_FINISH;
                    end
                end
                ST_READ_KICK: state_d = ST_WAIT_BIAS;
                ST_WAIT_BIAS: begin
                    if (bias_from_bram_valid) begin
                        state_d = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bias_ready) begin
                        state_d = ch_last ? ST_FINISH : ST_WAIT_BIAS;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: registered outputs are decoded from the state being entered
    always_comb begin
        write_en_d       = (state_d == ST_LOAD_KICK) || (state_d == ST_LOAD);
        transfer_start_d = (state_d == ST_LOAD_KICK) || (state_d == ST_READ_KICK);
        bram_add_d       = handshake && (state_d == ST_WAIT_BIAS);
        layer_finish_d   = (state_d == ST_FINISH);
        bias_valid_d     = (state_d == ST_PRESENT);
        busy_d           = (state_d != ST_IDLE);
        done_d           = (start_acc && size_zero) ||
                           (handshake && ch_last && !abort_act);
        to_cnt_d         = (state_q == ST_LOAD) ? to_cnt_q + TO_W'(1) : '0;
        ch_load          = start_acc && !size_zero;
        ch_clear         = (state_q == ST_FINISH);

        bias_data_d = bias_data_q;
        if ((state_q == ST_WAIT_BIAS) && bias_from_bram_valid && !abort_act) begin
            bias_data_d = bias_from_bram;
        end

        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if ((state_q == ST_LOAD) && !abort_act && !write_bias_finish && timeout_hit) begin
            err_d = 1'b1;
        end
    end

    assign write_en         = write_en_q;
    assign transfer_start   = transfer_start_q;
    assign bram_control_add = bram_add_q;
    assign layer_finish     = layer_finish_q;
    assign bias_data        = bias_data_q;
    assign bias_valid       = bias_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_timeout      = err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_bias_layer_sequencer.sv
// Scoreboard bench for bias_layer_sequencer: BRAM and PE-array models drive the
// DUT, expected words and per-layer pulse tallies are queued and checked by a monitor.
module tb_bias_layer_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 12;
    localparam int unsigned LT = 16;

    logic          clk = 1'b0;
    logic          rst, start, reload_bias, abort;
    logic [CW-1:0] output_channel_size;
    logic          write_bias_finish, bias_from_bram_valid, bias_ready;
    logic [DW-1:0] bias_from_bram;
    logic          write_en, transfer_start, bram_control_add, layer_finish;
    logic [DW-1:0] bias_data;
    logic          bias_valid, busy, done, err_timeout;
    logic [2:0]    state_o;

    bias_layer_sequencer #(
        .BRAM_DATA_WIDTH (DW),
        .CH_WIDTH        (CW),
        .LOAD_TIMEOUT    (LT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .reload_bias          (reload_bias),
        .abort                (abort),
        .output_channel_size  (output_channel_size),
        .write_bias_finish    (write_bias_finish),
        .bias_from_bram_valid (bias_from_bram_valid),
        .bias_from_bram       (bias_from_bram),
        .bias_ready           (bias_ready),
        .write_en             (write_en),
        .transfer_start       (transfer_start),
        .bram_control_add     (bram_control_add),
        .layer_finish         (layer_finish),
        .bias_data            (bias_data),
        .bias_valid           (bias_valid),
        .busy                 (busy),
        .done                 (done),
        .err_timeout          (err_timeout),
        .state_o              (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ts;
        int add;
        int lf;
        int dn;
        int err;
        int we;
        int stall;
    } layer_exp_t;

    layer_exp_t    layer_q[$];
    logic [DW-1:0] word_q[$];

    int n_cmp = 0, n_bad = 0;
    int load_delay = 1;
    int ready_mode = 0;
    int hold_left  = 0;
    int hs_base    = 0;
    int n_end = 0, n_hs = 0;
    int c_ts = 0, c_add = 0, c_we = 0, c_stall = 0;

    logic          prev_vld = 1'b0, prev_rdy = 1'b0, prev_abort = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-layer tallies, from the layer's parameters alone
    function automatic layer_exp_t model(input int size, input bit rel, input int ld, input int mode);
        layer_exp_t e;
        if (size == 0) begin
            e = '{ts: 0, add: 0, lf: 0, dn: 1, err: 0, we: 0, stall: 0};
        end else if (rel && ld <= 0) begin
            e = '{ts: 1, add: 0, lf: 1, dn: 0, err: 1, we: LT + 1, stall: -1};
        end else begin
            e.ts    = rel ? 2 : 1;
            e.add   = size - 1;
            e.lf    = 1;
            e.dn    = 1;
            e.err   = 0;
            e.we    = rel ? ld + 1 : 0;
            e.stall = (mode == 0) ? 0 : (mode == 2) ? 4 : -1;
        end
        return e;
    endfunction

    // PE array: ready policy per test
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bias_ready = 1'b1;
            1: bias_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bias_valid && hold_left > 0) begin
                    bias_ready = 1'b0;
                    hold_left--;
                end else begin
                    bias_ready = 1'b1;
                end
            end
            default: bias_ready = ((n_hs - hs_base) == 0);
        endcase
    end

    // BRAM read side: answer each read kick / advance with one random word
    initial begin
        int d;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            if (!rst && ((transfer_start && !write_en) || bram_control_add)) begin
                d = $urandom_range(0, 2);
                repeat (d + 1) @(posedge clk);
                #1;
                w = $urandom;
                bias_from_bram       = w;
                bias_from_bram_valid = 1'b1;
                word_q.push_back(w);
                @(posedge clk);
                #1;
                bias_from_bram_valid = 1'b0;
                bias_from_bram       = $urandom;
            end
        end
    end

    // BRAM write side: finish the load load_delay cycles after the load kick
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (!rst && transfer_start && write_en && load_delay > 0) begin
                d = load_delay;
                repeat (d) @(posedge clk);
                #1;
                write_bias_finish = 1'b1;
                @(posedge clk);
                #1;
                write_bias_finish = 1'b0;
            end
        end
    end

    // Monitor: scoreboard of words, hold checks and per-layer tallies
    always @(negedge clk) begin
        layer_exp_t e;
        logic [DW-1:0] w;
        if (rst) begin
            c_ts = 0; c_add = 0; c_we = 0; c_stall = 0;
            prev_vld = 1'b0; prev_rdy = 1'b0; prev_abort = 1'b0;
        end else begin
            if (transfer_start)   c_ts++;
            if (bram_control_add) c_add++;
            if (write_en)         c_we++;
            check("pulse_exclusive",
                  64'(int'(transfer_start) + int'(bram_control_add) + int'(layer_finish) <= 1), 64'd1);
            if (prev_vld && !prev_rdy && !prev_abort) begin
                check("hold_valid", 64'(bias_valid), 64'd1);
                check("hold_data", 64'(bias_data), 64'(prev_data));
            end
            if (bias_valid && !bias_ready) c_stall++;
            if (bias_valid && bias_ready) begin
                n_hs++;
                check("word_expected", 64'(word_q.size() != 0), 64'd1);
                if (word_q.size() != 0) begin
                    w = word_q.pop_front();
                    check("bias_data", 64'(bias_data), 64'(w));
                end
            end
            if (layer_finish || done) begin
                check("layer_expected", 64'(layer_q.size() != 0), 64'd1);
                if (layer_q.size() != 0) begin
                    e = layer_q.pop_front();
                    check("transfer_start_cnt", 64'(c_ts), 64'(e.ts));
                    check("bram_add_cnt", 64'(c_add), 64'(e.add));
                    check("layer_finish", 64'(layer_finish), 64'(e.lf));
                    check("done", 64'(done), 64'(e.dn));
                    check("err_timeout", 64'(err_timeout), 64'(e.err));
                    check("write_en_cycles", 64'(c_we), 64'(e.we));
                    if (e.stall >= 0) check("stall_cycles", 64'(c_stall), 64'(e.stall));
                end
                c_ts = 0; c_add = 0; c_we = 0; c_stall = 0;
                n_end++;
            end
            prev_vld   = bias_valid;
            prev_rdy   = bias_ready;
            prev_abort = abort;
            prev_data  = bias_data;
        end
    end

    task automatic wait_end(input int base);
        int g = 0;
        while (n_end == base && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("layer_end_seen", 64'(n_end != base), 64'd1);
    endtask

    task automatic pulse_start(input int size, input bit rel);
        @(posedge clk);
        #1;
        start               = 1'b1;
        reload_bias         = rel;
        output_channel_size = CW'(size);
        @(posedge clk);
        #1;
        start               = 1'b0;
        reload_bias         = 1'($urandom);
        output_channel_size = CW'($urandom);
    endtask

    task automatic run_layer(input int size, input bit rel, input int ld, input int mode, input bit poke);
        int base;
        ready_mode = mode;
        hold_left  = (mode == 2) ? 4 : 0;
        load_delay = ld;
        layer_q.push_back(model(size, rel, ld, mode));
        base = n_end;
        pulse_start(size, rel);
        if (poke && size > 0) pulse_start(7, 1'b1);
        wait_end(base);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_en"}, 64'(write_en), 64'd0);
        check({tag, "_transfer_start"}, 64'(transfer_start), 64'd0);
        check({tag, "_bram_add"}, 64'(bram_control_add), 64'd0);
        check({tag, "_layer_finish"}, 64'(layer_finish), 64'd0);
        check({tag, "_bias_data"}, 64'(bias_data), 64'd0);
        check({tag, "_bias_valid"}, 64'(bias_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
        check({tag, "_state"}, 64'(state_o), 64'd0);
    endtask

    initial begin
        int base;
        int g;
        rst = 1'b1; start = 1'b0; reload_bias = 1'b0; abort = 1'b0;
        output_channel_size = '0; write_bias_finish = 1'b0;
        bias_from_bram_valid = 1'b0; bias_from_bram = '0; bias_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reload, three channels, load finishes 5 cycles after the kick
        run_layer(3, 1'b1, 5, 0, 1'b0);
        // Read only, first word stalled 4 cycles
        run_layer(2, 1'b0, 0, 2, 1'b0);
        // Load never finishes: timeout
        run_layer(2, 1'b1, -1, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", 64'(err_timeout), 64'd1);
        // Zero-size start: done only, and it clears the sticky error
        run_layer(0, 1'b1, 1, 0, 1'b0);

        // Abort while channel 1 of 4 is presented
        ready_mode = 3;
        hs_base    = n_hs;
        load_delay = 1;
        layer_q.push_back('{ts: 1, add: 1, lf: 1, dn: 0, err: 0, we: 0, stall: -1});
        base = n_end;
        pulse_start(4, 1'b0);
        g = 0;
        while (!((n_hs - hs_base) == 1 && bias_valid) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("abort_reached_ch1", 64'((n_hs - hs_base) == 1 && bias_valid), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_drop", 64'(bias_valid), 64'd0);
        wait_end(base);
        word_q.delete();
        run_layer(2, 1'b0, 0, 0, 1'b0);

        // Reset in the middle of LOAD
        load_delay = -1;
        pulse_start(3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_write_en", 64'(write_en), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midload_reset");
        @(posedge clk);
        #1;

        // Randomised layers
        for (int i = 0; i < 25; i++) begin
            int sz;
            sz = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            run_layer(sz, 1'($urandom), int'($urandom_range(1, 10)),
                      int'($urandom_range(0, 2)), 1'($urandom));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("layers_drained", 64'(layer_q.size()), 64'd0);
        check("words_drained", 64'(word_q.size()), 64'd0);
        check("idle_at_end", 64'(busy), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bias_layer_sequencer.md
BIAS_LAYER_SEQUENCER -- requirements
Module: bias_layer_sequencer

Interface
REQ-001 Parameters SHALL be: BRAM_DATA_WIDTH, default 32, bias word width; CH_WIDTH, default 12, channel-count width; LOAD_TIMEOUT, default 4096, maximum cycles allowed for the load phase.
REQ-002 Ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  layer start pulse.
- reload_bias  in  1  sampled with start: 1 = load the bias BRAM first; 0 = read only.
- abort  in  1  cancel the current layer.
- output_channel_size  in  CH_WIDTH  channels in the layer; sampled at start.
- write_bias_finish  in  1  bias BRAM controller has completed writing.
- bias_from_bram_valid  in  1  one-cycle pulse; bias_from_bram is valid.
- bias_from_bram  in  BRAM_DATA_WIDTH  bias word read from the BRAM.
- bias_ready  in  1  PE array accepts the bias word.
- write_en  out  1  level; selects the write path of the bias BRAM controller.
- transfer_start  out  1  one-cycle pulse; restarts the bias BRAM controller.
- bram_control_add  out  1  one-cycle pulse; advances the bias BRAM controller to the next channel.
- layer_finish  out  1  one-cycle pulse; resets the bias BRAM controller's read FSM.
- bias_data  out  BRAM_DATA_WIDTH  bias word presented to the PE array.
- bias_valid  out  1  bias_data is valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer completes normally.
- err_timeout  out  1  sticky flag; load phase exceeded LOAD_TIMEOUT.
- state_o  out  3  current FSM state, for debug.

Function
REQ-003 The FSM SHALL have the states IDLE=0, LOAD_KICK=1, LOAD=2, READ_KICK=3, WAIT_BIAS=4, PRESENT=5, FINISH=6.
REQ-004 In IDLE, start with output_channel_size==0 SHALL stay in IDLE, pulse done the next cycle and generate no BRAM-side pulse.
REQ-005 In IDLE, start with a nonzero size SHALL latch size into ch_total, clear ch_cnt, and go to LOAD_KICK if reload_bias=1, otherwise to READ_KICK.
REQ-006 LOAD_KICK SHALL assert write_en and transfer_start for one cycle, then go to LOAD.
REQ-007 LOAD SHALL hold write_en=1; when write_bias_finish=1 it SHALL go to READ_KICK, and write_en SHALL be 0 from the next cycle.
REQ-008 LOAD SHALL count cycles; reaching LOAD_TIMEOUT without write_bias_finish SHALL set err_timeout and go to FINISH.
REQ-009 READ_KICK SHALL pulse transfer_start with write_en=0 for one cycle, then go to WAIT_BIAS.
REQ-010 In WAIT_BIAS, bias_from_bram_valid SHALL capture bias_from_bram into bias_data, set bias_valid on the next cycle, and go to PRESENT.
REQ-011 In PRESENT, bias_valid and bias_data SHALL stay stable until bias_ready=1.
REQ-012 On the bias_valid and bias_ready handshake, bias_valid SHALL drop on the next cycle, and:
- if ch_cnt==ch_total-1, the FSM SHALL go to FINISH;
- otherwise bram_control_add SHALL pulse for one cycle, ch_cnt SHALL increment, and the FSM SHALL go to WAIT_BIAS.
REQ-013 FINISH SHALL pulse layer_finish for one cycle; done SHALL pulse in the same cycle unless the layer ended by timeout; the FSM SHALL then go to IDLE.
REQ-014 abort SHALL have priority over every other event: from any non-IDLE state it SHALL clear bias_valid and write_en and go to FINISH without pulsing done.
REQ-015 start while busy SHALL be ignored.
REQ-016 ch_cnt and ch_total SHALL be CH_WIDTH bits wide; the comparison with ch_total-1 is only evaluated when ch_total is nonzero.
REQ-017 At most one of transfer_start, bram_control_add and layer_finish SHALL be high in any cycle.
REQ-018 err_timeout SHALL clear only on rst or on an accepted start.

Reset
REQ-019 While rst=1 at a rising edge:
- the state SHALL become IDLE;
- every output SHALL be 0, including bias_data and err_timeout;
- ch_cnt, ch_total and the timeout counter SHALL be 0.
REQ-020 Reset asserted mid-layer SHALL take effect at the next edge with no layer_finish pulse; the surrounding system resets the bias BRAM controller at the same time.

Structure
REQ-021 A shared package SHALL hold the state encoding constants and the default CH_WIDTH and LOAD_TIMEOUT values.
REQ-022 One sub-module, bias_chan_counter, SHALL hold ch_cnt, ch_total and the last-channel compare, with clear, load, increment and last ports.

Verification
REQ-023 size=3, reload_bias=1, write_bias_finish 5 cycles after the kick, bias_ready tied high: expect 1 load kick, 1 read kick, 3 bias_valid beats of words A/B/C, 2 bram_control_add pulses, then layer_finish and done together.
REQ-024 size=2, reload_bias=0, bias_ready low for 4 cycles on the first word: bias_valid holds with bias_data stable for 4 cycles; exactly one bram_control_add pulse after acceptance.
REQ-025 LOAD_TIMEOUT=16 with write_bias_finish never asserted: err_timeout rises at cycle 16 of LOAD, followed by a layer_finish pulse and no done.
REQ-026 start with size=0: one done pulse, no transfer_start, bram_control_add or layer_finish.
REQ-027 abort in PRESENT at channel 1 of 4: bias_valid drops next cycle, one layer_finish pulse, no done; a following start is accepted.
REQ-028 rst asserted in LOAD: at the next edge all outputs are 0 and state_o=0.
